msf_encoder: RTL and testbench

//  Transmit side of the MSF time-code sample interface: converts one (A,B) bit pair or a

---
 rtl/msf_encoder.sv | 205 ++++++++++++++++++++
 tb/tb_msf_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msf_encoder.sv
// MSF time-code transmit encoder: turns one buffered (A,B) pair or minute marker per second
// into a per-tick carrier-off/on sample stream. Optional noise injection via MSF_ENC_NOISE_EN.
module msf_encoder #(
    parameter int SAMPLES_PER_SEC = 100
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       bits_valid_i,
    output logic       bits_ready_o,
    input  logic       bits_is_second_00_i,
    input  logic [1:0] bits_data_i,
`ifdef MSF_ENC_NOISE_EN
    input  logic       noise_en_i,
`endif
    output logic       sample_valid_o,
    output logic       sample_data_o,
    output logic       underrun_o,
    output logic       state_o
);

    // Handshake: a pair transfers on any clock edge where bits_valid_i && bits_ready_o;
    // bits_ready_o comes straight from the hold-full register and never depends on inputs.

    localparam int SLOT  = SAMPLES_PER_SEC / 10;
    localparam int SUB_W = (SLOT > 1) ? $clog2(SLOT) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEC_IDLE   = 2'd0,
        SEC_NORMAL = 2'd1,
        SEC_S00    = 2'd2
    } sec_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_underrun_nxt;

    logic             r_hold_full;
    logic             r_hold_s00;
    logic [1:0]       r_hold_data;

    sec_t             r_act_kind;
    logic [1:0]       r_act_data;

    logic [SUB_W-1:0] r_sub_cnt;
    logic [3:0]       r_slot_cnt;

    logic             r_sample_valid;
    logic             r_sample_data;
    logic             r_underrun;

    logic             w_boundary;
    logic             w_load;
    logic             w_xfer;
    logic             w_sub_wrap;
    sec_t             w_cur_kind;
    logic [1:0]       w_cur_data;
    logic             w_pattern_bit;
    logic             w_noise_flip;

    assign w_boundary = tick_i && (r_slot_cnt == 4'd0) && (r_sub_cnt == '0);
    assign w_load     = w_boundary && r_hold_full;
    assign w_xfer     = bits_valid_i && !r_hold_full;
    assign w_sub_wrap = (r_sub_cnt == SUB_W'(SLOT - 1));

    // At a boundary the sample for slot 0 already belongs to the second being started.
    always_comb begin
        w_cur_kind = r_act_kind;
        w_cur_data = r_act_data;
        if (w_boundary) begin
            if (r_hold_full) begin
                w_cur_kind = r_hold_s00 ? SEC_S00 : SEC_NORMAL;
                w_cur_data = r_hold_data;
            end else begin
                w_cur_kind = SEC_IDLE;
                w_cur_data = 2'b00;
            end
        end
    end

    always_comb begin
        w_pattern_bit = 1'b0;
        case (w_cur_kind)
            SEC_NORMAL: begin
                case (r_slot_cnt)
                    4'd0:    w_pattern_bit = 1'b1;
                    4'd1:    w_pattern_bit = w_cur_data[1];
                    4'd2:    w_pattern_bit = w_cur_data[0];
                    default: w_pattern_bit = 1'b0;
                endcase
            end
            SEC_S00:  w_pattern_bit = (r_slot_cnt < 4'd5);
            default:  w_pattern_bit = 1'b0;
        endcase
    end

`ifdef MSF_ENC_NOISE_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_noise_flip = noise_en_i && (r_lfsr[7:0] == 8'h00);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= 16'hACE1;
        end else if (tick_i) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_noise_flip = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_underrun_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_boundary && !r_hold_full) begin
                    w_underrun_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A transfer only happens into an empty hold, a load only empties a full one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold_full <= 1'b0;
            r_hold_s00  <= 1'b0;
            r_hold_data <= 2'b00;
        end else if (w_xfer) begin
            r_hold_full <= 1'b1;
            r_hold_s00  <= bits_is_second_00_i;
            r_hold_data <= bits_data_i;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_act_kind <= SEC_IDLE;
            r_act_data <= 2'b00;
        end else if (w_boundary) begin
            r_act_kind <= w_cur_kind;
            r_act_data <= w_cur_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sub_cnt  <= '0;
            r_slot_cnt <= 4'd0;
        end else if (tick_i) begin
            if (w_sub_wrap) begin
                r_sub_cnt  <= '0;
                r_slot_cnt <= (r_slot_cnt == 4'd9) ? 4'd0 : r_slot_cnt + 4'd1;
            end else begin
                r_sub_cnt  <= r_sub_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sample_valid <= 1'b0;
            r_sample_data  <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_sample_valid <= tick_i;
            r_underrun     <= w_underrun_nxt;
            if (tick_i) begin
                r_sample_data <= w_pattern_bit ^ w_noise_flip;
            end
        end
    end

    assign bits_ready_o   = !r_hold_full;
    assign sample_valid_o = r_sample_valid;
    assign sample_data_o  = r_sample_data;
    assign underrun_o     = r_underrun;
    assign state_o        = r_state;

endmodule

// File: tb/tb_msf_encoder.sv
// Self-checking bench for msf_encoder: table-driven seconds, hand-written corner sequences and
// a randomized phase, all checked against a second-level behavioural model with an expected queue.
module tb_msf_encoder;

    localparam int SPS  = 100;
    localparam int SLOT = SPS / 10;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       bits_valid_i = 1'b0;
    logic       bits_ready_o;
    logic       bits_is_second_00_i = 1'b0;
    logic [1:0] bits_data_i = 2'b00;
    logic       sample_valid_o;
    logic       sample_data_o;
    logic       underrun_o;
    logic       state_o;
`ifdef MSF_ENC_NOISE_EN
    logic       noise_en_i = 1'b0;
`endif

    msf_encoder #(.SAMPLES_PER_SEC(SPS)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .tick_i              (tick_i),
        .bits_valid_i        (bits_valid_i),
        .bits_ready_o        (bits_ready_o),
        .bits_is_second_00_i (bits_is_second_00_i),
        .bits_data_i         (bits_data_i),
`ifdef MSF_ENC_NOISE_EN
        .noise_en_i          (noise_en_i),
`endif
        .sample_valid_o      (sample_valid_o),
        .sample_data_o       (sample_data_o),
        .underrun_o          (underrun_o),
        .state_o             (state_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: {underrun, sample} per issued tick
    logic [1:0] exp_q[$];

    // behavioural model of one second at a time
    int         m_tick_cnt;
    logic       m_hold_full;
    logic       m_hold_s00;
    logic [1:0] m_hold_d;
    int         m_kind;      // 0 idle second, 1 normal pair, 2 minute marker
    logic [1:0] m_act_d;
    logic       m_run;
    logic       m_last_data;

    typedef struct {
        logic       s00;
        logic [1:0] data;
        logic [9:0] mask;    // bit i = expected level in slot i
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic pattern(input int kind, input logic [1:0] d, input int slot);
        if (kind == 2) return (slot < 5);
        if (kind == 1) begin
            if (slot == 0) return 1'b1;
            if (slot == 1) return d[1];
            if (slot == 2) return d[0];
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_tick_cnt  = 0;
        m_hold_full = 1'b0;
        m_hold_s00  = 1'b0;
        m_hold_d    = 2'b00;
        m_kind      = 0;
        m_act_d     = 2'b00;
        m_run       = 1'b0;
        m_last_data = 1'b0;
        exp_q.delete();
    endtask

    // driver: one clock cycle with the given inputs, entered and left at a falling edge
    task automatic cycle(input logic t, input logic v, input logic s00, input logic [1:0] d,
                         output logic samp, output logic und);
        logic       exp_ready;
        logic       e_und;
        logic       e_bit;
        logic [1:0] e;
        int         k;
        tick_i              = t;
        bits_valid_i        = v;
        bits_is_second_00_i = s00;
        bits_data_i         = d;
        exp_ready = !m_hold_full;
        check("bits_ready", 32'(bits_ready_o), 32'(exp_ready));
        if (t) begin
            k     = m_tick_cnt % SPS;
            e_und = 1'b0;
            if (k == 0) begin
                if (m_hold_full) begin
                    m_kind      = m_hold_s00 ? 2 : 1;
                    m_act_d     = m_hold_d;
                    m_run       = 1'b1;
                    m_hold_full = 1'b0;
                end else begin
                    m_kind  = 0;
                    m_act_d = 2'b00;
                    e_und   = m_run;
                end
            end
            e_bit = pattern(m_kind, m_act_d, k / SLOT);
            exp_q.push_back({e_und, e_bit});
            m_last_data = e_bit;
            m_tick_cnt++;
        end
        if (v && exp_ready) begin
            m_hold_full = 1'b1;
            m_hold_s00  = s00;
            m_hold_d    = d;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        tick_i       = 1'b0;
        bits_valid_i = 1'b0;
        check("sample_valid", 32'(sample_valid_o), 32'(t));
        if (t) begin
            e = exp_q.pop_front();
            check("sample_data", 32'(sample_data_o), 32'(e[0]));
            check("underrun", 32'(underrun_o), 32'(e[1]));
        end else begin
            check("underrun_idle", 32'(underrun_o), 32'd0);
            check("sample_hold", 32'(sample_data_o), 32'(m_last_data));
        end
        check("state", 32'(state_o), 32'(m_run));
        samp = sample_data_o;
        und  = underrun_o;
    endtask

    task automatic do_reset(input int n);
        rst_i        = 1'b1;
        tick_i       = 1'b0;
        bits_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            check("rst_valid", 32'(sample_valid_o), 32'd0);
            check("rst_data", 32'(sample_data_o), 32'd0);
            check("rst_underrun", 32'(underrun_o), 32'd0);
            check("rst_ready", 32'(bits_ready_o), 32'd1);
        end
        rst_i = 1'b0;
        model_reset();
    endtask

    task automatic push(input logic s00, input logic [1:0] d);
        logic s, u;
        cycle(1'b0, 1'b1, s00, d, s, u);
    endtask

    task automatic tick_once(output logic samp, output logic und);
        logic s, u;
        cycle(1'b1, 1'b0, 1'b0, 2'b00, samp, und);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, s, u);
    endtask

    // n ticks; returns how many samples were 1 and how many underrun pulses occurred
    task automatic run_ticks(input int n, output int ones, output int unds);
        logic s, u;
        ones = 0;
        unds = 0;
        for (int i = 0; i < n; i++) begin
            tick_once(s, u);
            ones += int'(s);
            unds += int'(u);
        end
    endtask

    initial begin
        logic s, u;
        int   ones, unds;

        vecs[0] = '{s00: 1'b0, data: 2'b10, mask: 10'b0000000011};
        vecs[1] = '{s00: 1'b0, data: 2'b01, mask: 10'b0000000101};
        vecs[2] = '{s00: 1'b1, data: 2'b11, mask: 10'b0000011111};
        vecs[3] = '{s00: 1'b0, data: 2'b11, mask: 10'b0000000111};
        vecs[4] = '{s00: 1'b0, data: 2'b00, mask: 10'b0000000001};
        vecs[5] = '{s00: 1'b1, data: 2'b00, mask: 10'b0000011111};

        model_reset();
        @(negedge clk_i);
        do_reset(5);

        // one full second per table entry
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].s00, vecs[i].data);
            unds = 0;
            for (int k = 0; k < SPS; k++) begin
                tick_once(s, u);
                check("table_sample", 32'(s), 32'(vecs[i].mask[k / SLOT]));
                unds += int'(u);
            end
            check("table_no_underrun", 32'(unds), 32'd0);
        end

        // running with an empty hold: one underrun, an all-carrier-on second
        run_ticks(SPS, ones, unds);
        check("underrun_count", 32'(unds), 32'd1);
        check("idle_second_ones", 32'(ones), 32'd0);

        // boundary tick and transfer in the same cycle: pair waits for the next second
        cycle(1'b1, 1'b1, 1'b0, 2'b10, s, u);
        check("same_cycle_underrun", 32'(u), 32'd1);
        check("same_cycle_sample", 32'(s), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, s, u);
        run_ticks(SPS - 1, ones, unds);
        check("same_cycle_rest_ones", 32'(ones), 32'd0);
        run_ticks(SPS, ones, unds);
        check("deferred_pair_ones", 32'(ones), 32'd20);
        check("deferred_pair_unds", 32'(unds), 32'd0);

        // idle before first push never flags underrun
        do_reset(5);
        run_ticks(2 * SPS, ones, unds);
        check("idle_no_underrun", 32'(unds), 32'd0);
        check("idle_ones", 32'(ones), 32'd0);
        check("idle_state", 32'(state_o), 32'd0);

        // back-to-back pushes, ready timing, then reset mid-second
        do_reset(2);
        push(1'b0, 2'b11);
        tick_once(s, u);
        check("first_load_sample", 32'(s), 32'd1);
        push(1'b1, 2'b00);
        check("ready_after_push2", 32'(bits_ready_o), 32'd0);
        run_ticks(SPS - 1, ones, unds);
        check("ready_before_boundary", 32'(bits_ready_o), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 2'b00, s, u);
        check("ready_after_boundary", 32'(bits_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, s, u);
        run_ticks(37, ones, unds);
        do_reset(3);
        check("post_reset_state", 32'(state_o), 32'd0);
        push(1'b0, 2'b01);
        for (int k = 0; k < SPS; k++) begin
            tick_once(s, u);
            check("post_reset_sample", 32'(s), 32'(vecs[1].mask[k / SLOT]));
        end

        // consecutive ticks
        push(1'b1, 2'b01);
        for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 1'b0, 2'b00, s, u);

        // randomized traffic against the model
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), s, u);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 2'b00, s, u);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
